bit_serializer: RTL and testbench

//   Parallel-to-serial feeder for the serial sequence-detector stages (e.g. the 1011 Moore detector).

---
 rtl/bit_serializer.sv | 82 ++++++++
 tb/tb_bit_serializer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready word to serial bit stream with one-word holding buffer for gapless streaming
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CPEN = CW'(WIDTH - 2);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sh, hold, src;
  logic [CW-1:0] cnt;
  logic hold_full, accept, last, load_new, load_hold, hold_wr;
  function automatic logic first_bit(input logic [WIDTH-1:0] x);
    return MSB_FIRST ? x[WIDTH-1] : x[0];
  endfunction
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] x);
    return MSB_FIRST ? x << 1 : x >> 1;
  endfunction
  always_comb begin
    in_ready = (state == IDLE) || !hold_full;
    accept = in_valid && in_ready;
    last = (state == SHIFT) && (cnt == CMAX);
    load_hold = last && hold_full;
    load_new = accept && ((state == IDLE) || (last && !hold_full));
    hold_wr = accept && !load_new;
    src = load_hold ? hold : in_data;
    busy = (state == SHIFT) || hold_full;
    state_n = (state == IDLE) ? (accept ? SHIFT : IDLE)
            : ((last && !load_hold && !load_new) ? IDLE : SHIFT);
  end
  // dout is forced to 0 whenever no live bit is presented
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold_full <= 1'b0;
      hold <= '0;
      sh <= '0;
      cnt <= '0;
      dout <= 1'b0;
      dout_valid <= 1'b0;
      sof <= 1'b0;
      eof <= 1'b0;
    end else begin
      state <= state_n;
      hold_full <= hold_wr || (hold_full && !load_hold);
      if (hold_wr) hold <= in_data;
      if (load_new || load_hold) begin
        sh <= advance(src);
        dout <= first_bit(src);
        dout_valid <= 1'b1;
        sof <= 1'b1;
        eof <= 1'b0;
        cnt <= '0;
      end else if (state == SHIFT && !last) begin
        sh <= advance(sh);
        dout <= first_bit(sh);
        dout_valid <= 1'b1;
        sof <= 1'b0;
        eof <= (cnt == CPEN);
        cnt <= cnt + CW'(1);
      end else begin
        dout <= 1'b0;
        dout_valid <= 1'b0;
        sof <= 1'b0;
        eof <= 1'b0;
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: randomized and directed checks of bit_serializer against a bit-queue model
module tb_bit_serializer;
  logic clk = 0, rst = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, dout, dout_valid, sof, eof, busy;
  logic in_ready1, dout1, dout_valid1, sof1, eof1, busy1;
  int vectors = 0, errors = 0;
  bit qm[$], ql[$];
  int qp[$];
  logic [6:0] obs;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) u0 (.clk(clk), .rst(rst), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid),
    .sof(sof), .eof(eof), .busy(busy));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) u1 (.clk(clk), .rst(rst), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready1), .dout(dout1), .dout_valid(dout_valid1),
    .sof(sof1), .eof(eof1), .busy(busy1));

  always #5 clk = ~clk;
  assign obs = {dout_valid, dout, dout1, sof, eof, in_ready, busy};

  // Expected outputs: the front of the bit queue is the bit currently on dout
  function automatic logic [6:0] expv();
    logic [6:0] e;
    e = 7'b0000010;
    if (qm.size() > 0) e = {1'b1, qm[0], ql[0], qp[0] == 0, qp[0] == 7, 1'b0, 1'b1};
    e[1] = qm.size() <= 8;
    return e;
  endfunction

  task automatic step(input logic v, input logic [7:0] d, output bit acc);
    in_valid = v;
    in_data = d;
    acc = v && (qm.size() <= 8);
    @(posedge clk);
    if (qm.size() > 0) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
      void'(qp.pop_front());
    end
    if (acc)
      for (int i = 0; i < 8; i++) begin
        qm.push_back(d[7-i]);
        ql.push_back(d[i]);
        qp.push_back(i);
      end
    #1;
  endtask

  task automatic clear_model();
    qm.delete();
    ql.delete();
    qp.delete();
  endtask

  task automatic test_reset();
    bit acc;
    rst = 1;
    in_valid = 1;
    in_data = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    vectors++;
    if (obs !== 7'b0000010) begin
      errors++;
      $display("FAIL reset obs=%b exp=%b", obs, 7'b0000010);
    end
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      step(0, 8'hFF, acc);
      vectors++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL reset_idle cyc%0d obs=%b exp=%b", c, obs, expv());
      end
    end
  endtask

  task automatic test_single();
    bit acc;
    logic [7:0] got = 0;
    step(1, 8'b0101_1011, acc);
    for (int c = 0; c < 12; c++) begin
      vectors++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL single cyc%0d obs=%b exp=%b", c, obs, expv());
      end
      if (c < 8) got = {got[6:0], dout};
      step(0, 8'h00, acc);
    end
    vectors++;
    if (got !== 8'b0101_1011) begin
      errors++;
      $display("FAIL single_stream got=%b exp=%b", got, 8'b0101_1011);
    end
  endtask

  task automatic test_back_to_back();
    bit acc, saw_nr = 0;
    logic [15:0] got = 0;
    int run = 0, maxrun = 0, n = 0;
    logic [7:0] w [2];
    w[0] = 8'hB5;
    w[1] = 8'h2D;
    for (int c = 0; c < 24; c++) begin
      step(n < 2, n < 2 ? w[n] : 8'h00, acc);
      if (acc) n++;
      vectors++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL b2b cyc%0d obs=%b exp=%b", c, obs, expv());
      end
      if (!in_ready) saw_nr = 1;
      if (dout_valid) begin
        got = {got[14:0], dout};
        run++;
      end else run = 0;
      if (run > maxrun) maxrun = run;
    end
    vectors++;
    if (got !== 16'hB52D || maxrun != 16 || !saw_nr) begin
      errors++;
      $display("FAIL b2b_summary got=%h run=%0d nr=%0d exp=b52d/16/1", got, maxrun, saw_nr);
    end
  endtask

  task automatic test_hold_full();
    bit acc, saw_nr = 0;
    logic [23:0] got = 0, expw;
    logic [7:0] w [3];
    int n = 0, nb = 0;
    for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
    expw = {w[0], w[1], w[2]};
    for (int c = 0; c < 36; c++) begin
      step(n < 3, n < 3 ? w[n] : 8'h00, acc);
      if (acc) n++;
      if (n == 2 && !in_ready) saw_nr = 1;
      vectors++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL hold cyc%0d obs=%b exp=%b", c, obs, expv());
      end
      if (dout_valid) begin
        got = {got[22:0], dout};
        nb++;
      end
    end
    vectors++;
    if (got !== expw || nb != 24 || n != 3 || !saw_nr) begin
      errors++;
      $display("FAIL hold_summary got=%h exp=%h bits=%0d words=%0d stall=%0d", got, expw, nb, n, saw_nr);
    end
  endtask

  task automatic test_pattern();
    bit acc;
    logic [3:0] sr = 0;
    int hits = 0;
    step(1, 8'b1011_0110, acc);
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL pattern cyc%0d obs=%b exp=%b", c, obs, expv());
      end
      if (dout_valid) begin
        sr = {sr[2:0], dout};
        if (sr == 4'b1011) hits++;
      end
      step(0, 8'h00, acc);
    end
    vectors++;
    if (hits != 2) begin
      errors++;
      $display("FAIL pattern_hits got=%0d exp=2", hits);
    end
  endtask

  task automatic test_random();
    bit acc;
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), acc);
      vectors++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL random cyc%0d obs=%b exp=%b", c, obs, expv());
      end
    end
    for (int c = 0; c < 20; c++) begin
      step(0, 8'h00, acc);
      vectors++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL drain cyc%0d obs=%b exp=%b", c, obs, expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    logic [7:0] w, got = 0;
    step(1, 8'hFF, acc);
    step(1, 8'($urandom), acc);
    step(0, 8'h00, acc);
    vectors++;
    if (obs !== expv() || in_ready) begin
      errors++;
      $display("FAIL mid_pre obs=%b exp=%b", obs, expv());
    end
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    clear_model();
    vectors++;
    if (obs !== 7'b0000010) begin
      errors++;
      $display("FAIL mid_reset obs=%b exp=%b", obs, 7'b0000010);
    end
    w = 8'($urandom);
    step(1, w, acc);
    for (int c = 0; c < 12; c++) begin
      vectors++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL mid_after cyc%0d obs=%b exp=%b", c, obs, expv());
      end
      if (c < 8) got = {got[6:0], dout};
      step(0, 8'h00, acc);
    end
    vectors++;
    if (got !== w) begin
      errors++;
      $display("FAIL mid_stream got=%h exp=%h", got, w);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_full();
    test_pattern();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
